reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the 32x32 two-read-port MIPS register file.
- Configurable data width, depth and read-port count.
- Optional write-to-read bypass; register 0 is hardwired to zero.
- Integrated scoreboard tracks registers with an outstanding write from a multi-cycle producer, so the decode/hazard logic can stall on busy sources. Sits between decode and write-back in the pipelined core.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (>=1)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns stored value
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back data
- iss_en  in  1  issue strobe: mark iss_addr busy (pending producer)
- iss_addr  in  ADDR_W  destination of issued instruction
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k source has an unresolved pending write
- busy_cnt  out  ADDR_W+1  number of registers currently busy
- stall  out  1  OR of rd_busy

Behaviour:
- Reset: on a rising edge with rst=1, all registers are cleared to 0, all busy bits are cleared and busy_cnt is 0. rst overrides wr_en/iss_en in the same cycle.
- Reads are combinational with zero latency from rd_addr.
- Write: on rising edge, if wr_en=1, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Bypass hit (BYPASS=1): wr_en=1, wr_addr == port address, and the address is not the zero register. On a hit, rd_data = wr_data in the same cycle; otherwise rd_data = reg[addr].
- ZERO_REG=1: a read of address 0 always returns 0.
- Scoreboard: one busy bit per register.
  - Set at the next edge when iss_en=1.
  - Cleared at the next edge when wr_en=1 to that address.
  - iss_en and wr_en to the same address in the same cycle: busy ends set (new producer wins); data is still written.
  - iss_en to an already-busy register: busy stays 1; no error, no count change.
  - wr_en to a non-busy register: data is written; busy is unchanged.
  - ZERO_REG=1: iss_en/wr_en to address 0 never alter busy[0]; busy[0] is constant 0.
- rd_busy[k] = busy[rd_addr_k] AND NOT bypass hit on port k. A write landing this cycle resolves the hazard. With BYPASS=0, rd_busy[k] = busy[rd_addr_k].
- busy_cnt is registered and tracks the popcount of the busy bits exactly. Per edge, the net change is +1, -1 or 0 according to the set/clear rules above; simultaneous set of one address and clear of another gives 0.
  - busy_cnt never wraps: maximum is 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG=1), minimum is 0.
- stall = |rd_busy, combinational.
- Multiple read ports may address the same register and return identical data/busy.

Decomposition:
- reg_file_pkg holds:
  - default constants (DATA_W_DEF, ADDR_W_DEF, NUM_RD_DEF);
  - a function extracting field k from a flattened port bus.
- One sub-module, rf_scoreboard, owns the busy vector, the set/clear priority and busy_cnt (parameters ADDR_W, ZERO_REG).
- reg_file_sb instantiates rf_scoreboard and holds the storage array, the read muxes and the bypass compare per port (generate loop over NUM_RD).

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rd_data = 0x00000000, rd_busy = 0, busy_cnt = 0, stall = 0.
- Write 0xDEADBEEF to r5; next cycle read r5 on port0 and port1 -> both 0xDEADBEEF. Write 0x12345678 to r0, read r0 -> 0x00000000.
- BYPASS=1: wr_en, wr_addr=7, wr_data=0xA5A5A5A5 with rd_addr port0=7 in the same cycle -> rd_data0 = 0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> old value returned.
- Scoreboard:
  - iss r3, then iss r9 -> busy_cnt 1 then 2; rd_addr port1=3 -> rd_busy[1]=1, stall=1.
  - Next, wr r3 with port1 reading r3 -> rd_busy[1]=0 that cycle; after the edge busy_cnt=1.
- Simultaneous events: r4 busy; iss_en r4 and wr_en r4 in the same cycle -> busy[4] stays 1, busy_cnt unchanged, reg[4] updated. Also iss r10 with wr r4 -> busy_cnt unchanged, busy[4]=0, busy[10]=1.
- Reset mid-operation: 6 busy registers and a pending write, then assert rst for one cycle with wr_en=1, iss_en=1 -> all registers 0, busy_cnt 0, stall 0; the write is dropped.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared constants and helpers for the scoreboarded register file.
//   DATA_W_DEF / ADDR_W_DEF / NUM_RD_DEF : default geometry (32 x 32, 2 reads)
//   get_field()                          : pulls field k out of a flattened bus
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  // Widest flattened bus get_field() can take apart. Wider buses would have
  // to be split before extraction.
  localparam int FIELD_BUS_MAX = 1024;

  typedef logic [FIELD_BUS_MAX-1:0] field_bus_t;

  // Returns bits [k*w +: w] of a flattened bus, zero-extended to the full
  // helper width. The caller narrows the result back with a size cast.
  function automatic field_bus_t get_field(input field_bus_t  bus,
                                           input int unsigned k,
                                           input int unsigned w);
    field_bus_t mask;
    mask = (field_bus_t'(1) << w) - field_bus_t'(1);
    return (bus >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bundle between decode/write-back (master) and the register file (slave).
//   wr_en/wr_addr/wr_data : write-back port
//   iss_en/iss_addr       : issue of a multi-cycle producer, marks dest busy
//   rd_addr               : NUM_RD flattened read addresses
//   rd_data               : NUM_RD flattened read data
//   rd_busy               : per read port, source still has a pending write
//   busy_cnt              : number of registers currently busy
//   stall                 : OR of rd_busy
// ---------------------------------------------------------------------------
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       iss_en;
  logic [ADDR_W-1:0]          iss_addr;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [ADDR_W:0]            busy_cnt;
  logic                       stall;

  // Pipeline side: drives writes, issues and read addresses.
  modport master (
    output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
    input  rd_data, rd_busy, busy_cnt, stall
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
    output rd_data, rd_busy, busy_cnt, stall
  );

endinterface

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per register plus a registered count of busy bits.
//   clk, rst     : clock, synchronous active-high reset
//   set_en_i     : issue strobe, marks set_addr_i busy at the next edge
//   set_addr_i   : destination of the issued instruction
//   clr_en_i     : write-back strobe, clears clr_addr_i at the next edge
//   clr_addr_i   : write-back destination
//   busy_o       : busy vector, one bit per register
//   busy_cnt_o   : popcount of busy_o, kept incrementally
// ---------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en_i,
  input  logic [ADDR_W-1:0]       set_addr_i,
  input  logic                    clr_en_i,
  input  logic [ADDR_W-1:0]       clr_addr_i,
  output logic [(2**ADDR_W)-1:0]  busy_o,
  output logic [ADDR_W:0]         busy_cnt_o
);

  localparam int            DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set_eff, clr_eff;
  logic             cnt_inc, cnt_dec;

  // Next busy vector and count. A clear is applied before a set so an issue
  // and a write-back to the same register leave it busy: the newly issued
  // producer owns the register. The count only moves when a bit actually
  // flips, so re-issuing a busy register or writing a non-busy one is a no-op
  // and the count can never wrap in either direction.
  always_comb begin
    set_eff = set_en_i && !((ZERO_REG != 0) && (set_addr_i == '0));
    clr_eff = clr_en_i && !((ZERO_REG != 0) && (clr_addr_i == '0));

    busy_d = busy_q;
    if (clr_eff) busy_d[clr_addr_i] = 1'b0;
    if (set_eff) busy_d[set_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;

    cnt_inc = set_eff && !busy_q[set_addr_i];
    cnt_dec = clr_eff && busy_q[clr_addr_i] &&
              !(set_eff && (set_addr_i == clr_addr_i));

    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // State register; reset wins over any same-cycle issue or write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Parametrised register file with optional write-to-read bypass, optional
// hardwired zero register and an integrated busy scoreboard.
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_file_sb_if slave modport (write-back, issue, read ports,
//              rd_busy, busy_cnt, stall)
// ---------------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic                     wr_is_zero;
  logic [DATA_W-1:0]        rd_data_w [NUM_RD];
  logic [NUM_RD-1:0]        rd_busy_w;
  logic [NUM_RD*DATA_W-1:0] rd_data_flat;

  assign wr_is_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);

  // Storage array. Writes to the hardwired zero register are dropped so
  // that it still reads zero if ZERO_REG is later relaxed at a port level.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.wr_en && !wr_is_zero) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (bus.iss_en),
    .set_addr_i (bus.iss_addr),
    .clr_en_i   (bus.wr_en),
    .clr_addr_i (bus.wr_addr),
    .busy_o     (busy),
    .busy_cnt_o (bus.busy_cnt)
  );

  // Per read port: address extraction, bypass compare and read mux. A write
  // landing this cycle both forwards its data and resolves the hazard, so
  // the port is not reported busy on a bypass hit.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    logic              is_zero_k;
    logic              hit_k;

    assign addr_k    = ADDR_W'(get_field(field_bus_t'(bus.rd_addr), k, ADDR_W));
    assign is_zero_k = (ZERO_REG != 0) && (addr_k == '0);
    assign hit_k     = (BYPASS != 0) && bus.wr_en &&
                       (bus.wr_addr == addr_k) && !is_zero_k;

    assign rd_data_w[k] = is_zero_k ? '0 :
                          hit_k     ? bus.wr_data :
                                      mem_q[addr_k];
    assign rd_busy_w[k] = busy[addr_k] && !hit_k;
  end

  // Flatten the per-port read data back onto the interface bus.
  always_comb begin
    rd_data_flat = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_flat[k*DATA_W +: DATA_W] = rd_data_w[k];
    end
  end

  assign bus.rd_data = rd_data_flat;
  assign bus.rd_busy = rd_busy_w;
  assign bus.stall   = |rd_busy_w;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb. Two instances see identical stimulus: dut
// with bypass enabled and dut_nb with bypass disabled.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) rf_if ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) nb_if ();

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if.slave)
  );

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (nb_if.slave)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both instances with the same stimulus.
  task automatic applyStimulus(input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ie,
                               input logic [4:0] ia, input logic [4:0] r0,
                               input logic [4:0] r1);
    rf_if.wr_en    = we;  nb_if.wr_en    = we;
    rf_if.wr_addr  = wa;  nb_if.wr_addr  = wa;
    rf_if.wr_data  = wd;  nb_if.wr_data  = wd;
    rf_if.iss_en   = ie;  nb_if.iss_en   = ie;
    rf_if.iss_addr = ia;  nb_if.iss_addr = ia;
    rf_if.rd_addr  = {r1, r0};
    nb_if.rd_addr  = {r1, r0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a));
      #1;
      compared++;
      if (rf_if.rd_data !== 64'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_rd_data addr=%0d got=%h exp=%h", a, rf_if.rd_data, 64'h0);
      end
      compared++;
      if (rf_if.rd_busy !== 2'b00 || rf_if.stall !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_busy addr=%0d got=%b/%b exp=00/0", a, rf_if.rd_busy, rf_if.stall);
      end
    end
    compared++;
    if (rf_if.busy_cnt !== 6'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy_cnt got=%0d exp=0", rf_if.busy_cnt);
    end
  endtask

  task automatic test_write_read();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
    compared++;
    if (rf_if.rd_data[31:0] !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL r5_port0 got=%h exp=%h", rf_if.rd_data[31:0], 32'hDEADBEEF);
    end
    compared++;
    if (rf_if.rd_data[63:32] !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL r5_port1 got=%h exp=%h", rf_if.rd_data[63:32], 32'hDEADBEEF);
    end
    // r0 write is dropped; the same-cycle read must not bypass it either.
    applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    compared++;
    if (rf_if.rd_data[31:0] !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL r0_bypass got=%h exp=%h", rf_if.rd_data[31:0], 32'h0);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    compared++;
    if (rf_if.rd_data !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL r0_read got=%h exp=%h", rf_if.rd_data, 64'h0);
    end
  endtask

  task automatic test_bypass();
    applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd5);
    #1;
    compared++;
    if (rf_if.rd_data[31:0] !== 32'hA5A5A5A5) begin
      mismatched++;
      $display("[TB] FAIL bypass_hit got=%h exp=%h", rf_if.rd_data[31:0], 32'hA5A5A5A5);
    end
    compared++;
    if (nb_if.rd_data[31:0] !== 32'h11111111) begin
      mismatched++;
      $display("[TB] FAIL nobypass_old got=%h exp=%h", nb_if.rd_data[31:0], 32'h11111111);
    end
    compared++;
    if (rf_if.rd_data[63:32] !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL bypass_other_port got=%h exp=%h", rf_if.rd_data[63:32], 32'hDEADBEEF);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    compared++;
    if (nb_if.rd_data !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      mismatched++;
      $display("[TB] FAIL nobypass_after got=%h exp=%h", nb_if.rd_data, {32'hA5A5A5A5, 32'hA5A5A5A5});
    end
  endtask

  task automatic test_scoreboard();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    compared++;
    if (rf_if.busy_cnt !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL iss_r3_cnt got=%0d exp=1", rf_if.busy_cnt);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    compared++;
    if (rf_if.busy_cnt !== 6'd2) begin
      mismatched++;
      $display("[TB] FAIL iss_r9_cnt got=%0d exp=2", rf_if.busy_cnt);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
    #1;
    compared++;
    if (rf_if.rd_busy !== 2'b10 || rf_if.stall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL r3_busy got=%b/%b exp=10/1", rf_if.rd_busy, rf_if.stall);
    end
    // Write-back of r3 resolves the hazard in the same cycle with bypass.
    applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 5'd0, 5'd3);
    #1;
    compared++;
    if (rf_if.rd_busy !== 2'b00 || rf_if.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wb_r3_busy got=%b/%b exp=00/0", rf_if.rd_busy, rf_if.stall);
    end
    compared++;
    if (nb_if.rd_busy !== 2'b10 || nb_if.stall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wb_r3_busy_nb got=%b/%b exp=10/1", nb_if.rd_busy, nb_if.stall);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3);
    #1;
    compared++;
    if (rf_if.busy_cnt !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL wb_r3_cnt got=%0d exp=1", rf_if.busy_cnt);
    end
    compared++;
    if (rf_if.rd_busy !== 2'b01 || rf_if.rd_data[63:32] !== 32'h00000033) begin
      mismatched++;
      $display("[TB] FAIL after_wb got=%b/%h exp=01/00000033", rf_if.rd_busy, rf_if.rd_data[63:32]);
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    compared++;
    if (rf_if.busy_cnt !== 6'd2) begin
      mismatched++;
      $display("[TB] FAIL iss_r4_cnt got=%0d exp=2", rf_if.busy_cnt);
    end
    applyStimulus(1'b1, 5'd4, 32'h00000044, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
    #1;
    compared++;
    if (rf_if.busy_cnt !== 6'd2 || rf_if.rd_busy !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL same_addr got=%0d/%b exp=2/01", rf_if.busy_cnt, rf_if.rd_busy);
    end
    compared++;
    if (rf_if.rd_data[31:0] !== 32'h00000044) begin
      mismatched++;
      $display("[TB] FAIL same_addr_data got=%h exp=%h", rf_if.rd_data[31:0], 32'h00000044);
    end
    applyStimulus(1'b1, 5'd4, 32'h00000045, 1'b1, 5'd10, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd10);
    #1;
    compared++;
    if (rf_if.busy_cnt !== 6'd2 || rf_if.rd_busy !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL set_clr_diff got=%0d/%b exp=2/10", rf_if.busy_cnt, rf_if.rd_busy);
    end
    // Issue to r0 and write to a non-busy register: no count change.
    applyStimulus(1'b1, 5'd5, 32'h55555555, 1'b1, 5'd0, 5'd0, 5'd5);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5);
    #1;
    compared++;
    if (rf_if.busy_cnt !== 6'd2 || rf_if.rd_busy !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL r0_iss_nonbusy_wr got=%0d/%b exp=2/00", rf_if.busy_cnt, rf_if.rd_busy);
    end
    compared++;
    if (rf_if.rd_data[63:32] !== 32'h55555555) begin
      mismatched++;
      $display("[TB] FAIL nonbusy_wr_data got=%h exp=%h", rf_if.rd_data[63:32], 32'h55555555);
    end
  endtask

  task automatic test_reset_mid();
    for (int a = 11; a <= 14; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'd0, 5'd0);
      tick();
    end
    compared++;
    if (rf_if.busy_cnt !== 6'd6) begin
      mismatched++;
      $display("[TB] FAIL six_busy_cnt got=%0d exp=6", rf_if.busy_cnt);
    end
    rst = 1'b1;
    applyStimulus(1'b1, 5'd20, 32'hFFFF0000, 1'b1, 5'd21, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd21);
    #1;
    compared++;
    if (rf_if.busy_cnt !== 6'd0 || rf_if.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_busy got=%0d/%b exp=0/0", rf_if.busy_cnt, rf_if.stall);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd5);
    #1;
    compared++;
    if (rf_if.rd_data !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_data got=%h exp=%h", rf_if.rd_data, 64'h0);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd0, 5'd0);
    tick();
    compared++;
    if (rf_if.busy_cnt !== 6'd31) begin
      mismatched++;
      $display("[TB] FAIL full_cnt got=%0d exp=31", rf_if.busy_cnt);
    end
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b1, 5'(a), 32'(a), 1'b0, 5'd0, 5'(a), 5'd0);
      #1;
      compared++;
      if (rf_if.rd_busy[0] !== 1'b0 || nb_if.rd_busy[0] !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL drain_busy addr=%0d got=%b/%b exp=0/1", a, rf_if.rd_busy[0], nb_if.rd_busy[0]);
      end
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd17, 5'd31);
    #1;
    compared++;
    if (rf_if.busy_cnt !== 6'd0) begin
      mismatched++;
      $display("[TB] FAIL drained_cnt got=%0d exp=0", rf_if.busy_cnt);
    end
    compared++;
    if (rf_if.rd_data !== {32'd31, 32'd17}) begin
      mismatched++;
      $display("[TB] FAIL drained_data got=%h exp=%h", rf_if.rd_data, {32'd31, 32'd17});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
